gamepad_pmod_events: RTL and testbench

- Parametrised successor to the single/dual Gamepad Pmod interface. Deserialises an N-controller serial stream and validates each frame by bit count and link timeout.
- Outputs per controller: level button states, one-cycle press/release event pulses, and frame-counted auto-repeat on selected buttons (D-pad by default).
- Sits between the ui_in Pmod pins and game logic, so game FSMs no longer need their own edge detectors.

---
 rtl/gamepad_pmod_events.sv | 115 +++++++++++
 tb/tb_gamepad_pmod_events.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gamepad_pmod_events.sv
// gamepad_pmod_events: N-pad Gamepad Pmod deserialiser (pins pmod_data/clk/latch in; held/press/released/is_present/frame_valid/frame_err/link_ok out)
module gamepad_pmod_events #(
  parameter int          NUM_PADS       = 2,
  parameter logic [11:0] REPEAT_MASK    = 12'h0F0,
  parameter int          REPEAT_DELAY   = 15,
  parameter int          REPEAT_RATE    = 4,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pmod_data,
  input  logic                    pmod_clk,
  input  logic                    pmod_latch,
  output logic [12*NUM_PADS-1:0]  held,
  output logic [12*NUM_PADS-1:0]  press,
  output logic [12*NUM_PADS-1:0]  released,
  output logic [NUM_PADS-1:0]     is_present,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    link_ok
);
  localparam int W = 12 * NUM_PADS;
  localparam int CW = $clog2(W + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(W);
  localparam logic [CW-1:0] SAT = CW'(W + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] DLY = 8'(REPEAT_DELAY);
  localparam logic [7:0] RLD = 8'(REPEAT_DELAY - REPEAT_RATE);
  logic [1:0] data_s_q, data_s_d;
  logic [2:0] clk_s_q, clk_s_d, latch_s_q, latch_s_d;
  logic [W-1:0] shift_q, shift_d, held_q, held_d, press_q, press_d, rel_q, rel_d, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [NUM_PADS-1:0] pres_q, pres_d, pres_nxt;
  logic valid_q, valid_d, err_q, err_d, link_q, link_d;
  logic [7:0] rc_q [W];
  logic [7:0] rc_d [W];
  logic clk_rise, latch_rise, acc, lost;
  always_comb begin
    data_s_d = {data_s_q[0], pmod_data};
    clk_s_d = {clk_s_q[1:0], pmod_clk};
    latch_s_d = {latch_s_q[1:0], pmod_latch};
    clk_rise = clk_s_q[1] & ~clk_s_q[2];
    latch_rise = latch_s_q[1] & ~latch_s_q[2];
    acc = latch_rise & (cnt_q == FULL);
    lost = ~acc & (to_q == TLAST);
    shift_d = clk_rise ? {shift_q[W-2:0], data_s_q[1]} : shift_q;
    cnt_d = latch_rise ? CW'(clk_rise) : (clk_rise && cnt_q != SAT) ? cnt_q + 1'b1 : cnt_q;
    to_d = acc ? '0 : (to_q != TMAX) ? to_q + 1'b1 : to_q;
    for (int k = 0; k < NUM_PADS; k++) begin
      pres_nxt[k] = shift_q[12*k +: 12] != 12'hFFF;
      nxt[12*k +: 12] = pres_nxt[k] ? shift_q[12*k +: 12] : 12'h000;
    end
    press_d = acc ? nxt & ~held_q : '0;
    rel_d = acc ? ~nxt & held_q : lost ? held_q : '0;
    for (int i = 0; i < W; i++) begin
      rc_d[i] = rc_q[i];
      if (!REPEAT_MASK[i % 12] || lost) rc_d[i] = '0;
      else if (acc) begin
        if (!nxt[i] || !held_q[i]) rc_d[i] = '0;
        else if (rc_q[i] + 8'd1 == DLY) begin
          rc_d[i] = RLD;
          press_d[i] = 1'b1;
        end else rc_d[i] = rc_q[i] + 8'd1;
      end
    end
    held_d = acc ? nxt : lost ? '0 : held_q;
    pres_d = acc ? pres_nxt : lost ? '0 : pres_q;
    valid_d = acc;
    err_d = latch_rise & ~acc;
    link_d = acc | (link_q & ~lost);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_s_q <= '0;
      clk_s_q <= '0;
      latch_s_q <= '0;
      shift_q <= '1;
      cnt_q <= '0;
      to_q <= '0;
      held_q <= '0;
      press_q <= '0;
      rel_q <= '0;
      pres_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      link_q <= 1'b0;
      rc_q <= '{default: '0};
    end else begin
      data_s_q <= data_s_d;
      clk_s_q <= clk_s_d;
      latch_s_q <= latch_s_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      held_q <= held_d;
      press_q <= press_d;
      rel_q <= rel_d;
      pres_q <= pres_d;
      valid_q <= valid_d;
      err_q <= err_d;
      link_q <= link_d;
      rc_q <= rc_d;
    end
  end
  assign held = held_q;
  assign press = press_q;
  assign released = rel_q;
  assign is_present = pres_q;
  assign frame_valid = valid_q;
  assign frame_err = err_q;
  assign link_ok = link_q;
endmodule

// File: tb/tb_gamepad_pmod_events.sv
// tb_gamepad_pmod_events: randomized, model-checked bench for gamepad_pmod_events
module tb_gamepad_pmod_events;
  localparam int NP = 2, W = 24, DELAY = 15, RATE = 4, TO = 200;
  localparam logic [11:0] MASK = 12'h0F0;
  logic clk = 1'b0, rst_n = 1'b0, pmod_data = 1'b0, pmod_clk = 1'b0, pmod_latch = 1'b0;
  logic [W-1:0] held, press, released;
  logic [NP-1:0] is_present;
  logic frame_valid, frame_err, link_ok;
  int checks = 0, failures = 0;
  logic [W-1:0] m_held, e_press, e_rel;
  logic [NP-1:0] m_pres;
  int m_n [W];
  logic c_ok, c_v, c_e, c_l;
  logic [W-1:0] c_h, c_p, c_r, c_pn, c_rn;
  logic [NP-1:0] c_pr;
  gamepad_pmod_events #(.NUM_PADS(NP), .REPEAT_MASK(MASK), .REPEAT_DELAY(DELAY),
                        .REPEAT_RATE(RATE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .pmod_data(pmod_data), .pmod_clk(pmod_clk),
    .pmod_latch(pmod_latch), .held(held), .press(press), .released(released),
    .is_present(is_present), .frame_valid(frame_valid), .frame_err(frame_err),
    .link_ok(link_ok));
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic model_reset();
    m_held = '0;
    m_pres = '0;
    for (int i = 0; i < W; i++) m_n[i] = 0;
  endtask
  // a held bit presses on its 1st frame, then repeats on frame DELAY+1 and every RATE frames after
  task automatic model_accept(input logic [W-1:0] v);
    logic [W-1:0] nw;
    for (int k = 0; k < NP; k++) begin
      m_pres[k] = v[12*k +: 12] != 12'hFFF;
      nw[12*k +: 12] = m_pres[k] ? v[12*k +: 12] : 12'h000;
    end
    for (int i = 0; i < W; i++) begin
      m_n[i] = nw[i] ? (m_held[i] ? m_n[i] + 1 : 1) : 0;
      e_press[i] = nw[i] && (m_n[i] == 1 || (MASK[i % 12] && m_n[i] > DELAY && (m_n[i] - 1 - DELAY) % RATE == 0));
      e_rel[i] = m_held[i] && !nw[i];
    end
    m_held = nw;
  endtask
  task automatic send_bits(input logic [W-1:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      pmod_data = v[i];
      pmod_clk = 1'b0;
      tick();
      pmod_clk = 1'b1;
      tick();
    end
    pmod_clk = 1'b0;
    tick();
  endtask
  task automatic latch_frame();
    c_ok = 1'b0;
    {c_v, c_e, c_l, c_h, c_p, c_r, c_pr} = '0;
    pmod_latch = 1'b1;
    for (int c = 0; c < 10 && !c_ok; c++) begin
      tick();
      if (c == 1) pmod_latch = 1'b0;
      if (frame_valid || frame_err) begin
        c_ok = 1'b1;
        {c_v, c_e, c_l, c_h, c_p, c_r, c_pr} = {frame_valid, frame_err, link_ok, held, press, released, is_present};
      end
    end
    pmod_latch = 1'b0;
    tick();
    c_pn = press;
    c_rn = released;
  endtask
  task automatic do_frame(input logic [W-1:0] v);
    send_bits(v, W);
    latch_frame();
  endtask
  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if ({held, press, released} !== '0) begin failures++; $display("FAIL reset_vectors got=%h exp=0", {held, press, released}); end
    checks++; if ({is_present, frame_valid, frame_err, link_ok} !== '0) begin failures++; $display("FAIL reset_flags got=%b exp=0", {is_present, frame_valid, frame_err, link_ok}); end
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_first_frame();
    do_frame({12'hFFF, 12'h080});
    model_accept({12'hFFF, 12'h080});
    checks++; if (c_ok !== 1'b1 || c_v !== 1'b1 || c_e !== 1'b0) begin failures++; $display("FAIL first_valid got ok=%b v=%b e=%b exp 1 1 0", c_ok, c_v, c_e); end
    checks++; if (c_h !== 24'h000080) begin failures++; $display("FAIL first_held got=%h exp=000080", c_h); end
    checks++; if (c_pr !== 2'b01) begin failures++; $display("FAIL first_present got=%b exp=01", c_pr); end
    checks++; if (c_p !== 24'h000080 || c_r !== '0) begin failures++; $display("FAIL first_events got p=%h r=%h exp 000080 0", c_p, c_r); end
    checks++; if (c_l !== 1'b1) begin failures++; $display("FAIL first_link got=%b exp=1", c_l); end
    checks++; if (c_pn !== '0) begin failures++; $display("FAIL first_pulse_width got=%h exp=0", c_pn); end
  endtask
  task automatic test_repeat();
    int pc = 0;
    for (int f = 2; f <= 30; f++) begin
      do_frame({12'hFFF, 12'h080});
      model_accept({12'hFFF, 12'h080});
      if (c_p[7]) pc++;
      checks++; if (!c_ok || c_v !== 1'b1 || c_p !== e_press || c_r !== e_rel) begin failures++; $display("FAIL repeat_frame f=%0d got v=%b p=%h r=%h exp p=%h r=%h", f, c_v, c_p, c_r, e_press, e_rel); end
    end
    checks++; if (pc !== 4) begin failures++; $display("FAIL repeat_count got=%0d exp=4", pc); end
    do_frame({12'hFFF, 12'h000});
    model_accept({12'hFFF, 12'h000});
    checks++; if (c_r !== 24'h000080 || c_p !== '0) begin failures++; $display("FAIL repeat_release got r=%h p=%h exp r=000080 p=0", c_r, c_p); end
    checks++; if (c_rn !== '0 || c_pn !== '0) begin failures++; $display("FAIL repeat_release_width got r=%h p=%h exp 0", c_rn, c_pn); end
  endtask
  task automatic test_frame_err();
    do_frame({12'h000, 12'h011});
    model_accept({12'h000, 12'h011});
    send_bits({12'h3C0, 12'h022}, 23);
    latch_frame();
    checks++; if (!c_ok || c_e !== 1'b1 || c_v !== 1'b0) begin failures++; $display("FAIL err_flag got ok=%b e=%b v=%b exp 1 1 0", c_ok, c_e, c_v); end
    checks++; if (c_h !== m_held || c_p !== '0 || c_r !== '0) begin failures++; $display("FAIL err_unchanged got h=%h p=%h r=%h exp h=%h", c_h, c_p, c_r, m_held); end
    do_frame({12'h000, 12'h012});
    model_accept({12'h000, 12'h012});
    checks++; if (!c_ok || c_v !== 1'b1 || c_h !== m_held || c_p !== e_press || c_r !== e_rel || c_pr !== m_pres) begin failures++; $display("FAIL err_recover got v=%b h=%h p=%h r=%h exp h=%h p=%h r=%h", c_v, c_h, c_p, c_r, m_held, e_press, e_rel); end
  endtask
  task automatic test_non_repeat();
    int pc = 0;
    for (int f = 1; f <= 40; f++) begin
      do_frame({12'hFFF, 12'h008});
      model_accept({12'hFFF, 12'h008});
      if (c_p[3]) pc++;
      checks++; if (!c_ok || c_p !== e_press || c_r !== e_rel || c_h !== m_held) begin failures++; $display("FAIL nonrep_frame f=%0d got p=%h r=%h h=%h exp p=%h r=%h h=%h", f, c_p, c_r, c_h, e_press, e_rel, m_held); end
    end
    checks++; if (pc !== 1) begin failures++; $display("FAIL nonrep_count got=%0d exp=1", pc); end
  endtask
  task automatic test_random();
    logic [W-1:0] v = m_held;
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < NP; k++) begin
        int r = $urandom_range(0, 9);
        if (r == 0) v[12*k +: 12] = 12'hFFF;
        else if (r > 5) v[12*k +: 12] = 12'($urandom);
      end
      do_frame(v);
      model_accept(v);
      checks++; if (!c_ok || c_v !== 1'b1 || c_h !== m_held || c_p !== e_press || c_r !== e_rel || c_pr !== m_pres || c_l !== 1'b1) begin failures++; $display("FAIL random_frame f=%0d in=%h got h=%h p=%h r=%h pr=%b exp h=%h p=%h r=%h pr=%b", f, v, c_h, c_p, c_r, c_pr, m_held, e_press, e_rel, m_pres); end
    end
  endtask
  task automatic test_timeout();
    int waited = 0;
    do_frame({12'h000, 12'h011});
    model_accept({12'h000, 12'h011});
    while (link_ok && waited < TO + 50) begin
      tick();
      waited++;
    end
    checks++; if (link_ok !== 1'b0 || waited < TO - 5 || waited > TO + 5) begin failures++; $display("FAIL timeout_link got link=%b after=%0d exp link=0 after~%0d", link_ok, waited, TO); end
    checks++; if (released !== 24'h000011) begin failures++; $display("FAIL timeout_release got=%h exp=000011", released); end
    tick();
    model_reset();
    checks++; if (held !== '0 || is_present !== '0 || released !== '0) begin failures++; $display("FAIL timeout_clear got h=%h pr=%b r=%h exp 0", held, is_present, released); end
    do_frame({12'h000, 12'h011});
    model_accept({12'h000, 12'h011});
    checks++; if (!c_ok || c_v !== 1'b1 || c_l !== 1'b1 || c_p !== e_press || c_h !== m_held) begin failures++; $display("FAIL timeout_recover got v=%b l=%b p=%h h=%h exp v=1 l=1 p=%h h=%h", c_v, c_l, c_p, c_h, e_press, m_held); end
  endtask
  task automatic test_reset_mid();
    for (int f = 0; f < 17; f++) begin
      do_frame({12'h040, 12'h080});
      model_accept({12'h040, 12'h080});
      checks++; if (!c_ok || c_p !== e_press || c_r !== e_rel) begin failures++; $display("FAIL midrep_frame f=%0d got p=%h r=%h exp p=%h r=%h", f, c_p, c_r, e_press, e_rel); end
    end
    for (int i = 23; i > 13; i--) begin
      pmod_data = 1'b0;
      pmod_clk = 1'b0;
      tick();
      pmod_clk = 1'b1;
      tick();
    end
    pmod_clk = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({held, press, released, is_present, frame_valid, frame_err, link_ok} !== '0) begin failures++; $display("FAIL async_reset got h=%h pr=%b l=%b exp 0", held, is_present, link_ok); end
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send_bits({12'h000, 12'h080}, 14);
    latch_frame();
    checks++; if (!c_ok || c_e !== 1'b1 || c_v !== 1'b0 || c_h !== '0) begin failures++; $display("FAIL reset_short_frame got ok=%b e=%b v=%b h=%h exp 1 1 0 0", c_ok, c_e, c_v, c_h); end
    do_frame({12'h040, 12'h080});
    model_accept({12'h040, 12'h080});
    checks++; if (!c_ok || c_v !== 1'b1 || c_p !== e_press || c_h !== m_held || c_pr !== m_pres) begin failures++; $display("FAIL reset_recover got v=%b p=%h h=%h exp p=%h h=%h", c_v, c_p, c_h, e_press, m_held); end
  endtask
  initial begin
    test_reset();
    test_first_frame();
    test_repeat();
    test_frame_err();
    test_non_repeat();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
